// File: rtl/lsu.sv
// Load/store and writeback stage: one instruction in flight, aligned memory access over a
// valid/ready request port, load formatting, and a one-cycle registered writeback strobe.
module lsu #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      exu_valid,
    output logic                      lsu_ready,
    input  logic [DATA_WIDTH-1:0]     exu_result,
    input  logic [DATA_WIDTH-1:0]     exu_sdata,
    input  logic [REG_ADDR_WIDTH-1:0] exu_rd,
    input  logic                      exu_rd_wen,
    input  logic                      exu_load,
    input  logic                      exu_store,
    input  logic [2:0]                exu_funct3,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_wen,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [3:0]                mem_wstrb,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      lsu_valid,
    output logic                      wen,
    output logic [REG_ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic                      lsu_fault
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]                state_q, state_d;
    logic                      load_q, store_q, rd_wen_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [2:0]                funct3_q;
    logic [1:0]                addr_lo_q;
    logic [DATA_WIDTH-1:0]     result_q;

    // Decode of the offered instruction; a load wins if both flags are set.
    logic                  acc_store, acc_mem, f3_legal, misalign, acc_fault, acc_wen;
    logic [3:0]            acc_wstrb;
    logic [DATA_WIDTH-1:0] acc_wdata;

    always_comb begin
        acc_store = exu_store & ~exu_load;
        acc_mem   = exu_load | exu_store;
        f3_legal  = 1'b0;
        if (exu_load) begin
            unique case (exu_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                f3_legal = 1'b0;
            endcase
        end else begin
            f3_legal = (exu_funct3 == 3'b000) || (exu_funct3 == 3'b001) ||
                       (exu_funct3 == 3'b010);
        end
        misalign  = ((exu_funct3[1:0] == 2'b01) && exu_result[0]) ||
                    ((exu_funct3[1:0] == 2'b10) && (exu_result[1:0] != 2'b00));
        acc_fault = acc_mem & (~f3_legal | misalign);
        acc_wen   = exu_rd_wen & ~exu_store & ~acc_fault & (exu_rd != '0);

        acc_wstrb = 4'b1111;
        acc_wdata = exu_sdata;
        unique case (exu_funct3[1:0])
            2'b00: begin
                acc_wstrb = 4'b0001 << exu_result[1:0];
                acc_wdata = {4{exu_sdata[7:0]}};
            end
            2'b01: begin
                acc_wstrb = 4'b0011 << exu_result[1:0];
                acc_wdata = {2{exu_sdata[15:0]}};
            end
            default: begin
                acc_wstrb = 4'b1111;
                acc_wdata = exu_sdata;
            end
        endcase
    end

    logic [DATA_WIDTH-1:0] rdata_shift, load_fmt;
    logic                  done_wen;

    always_comb begin
        rdata_shift = mem_rdata >> {addr_lo_q, 3'b000};
        unique case (funct3_q)
            3'b000:  load_fmt = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_fmt = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_fmt = {24'd0, rdata_shift[7:0]};
            3'b101:  load_fmt = {16'd0, rdata_shift[15:0]};
            default: load_fmt = rdata_shift;
        endcase
        done_wen = rd_wen_q & ~store_q & (rd_q != '0);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (exu_valid) state_d = (acc_mem && !acc_fault) ? REQ : DONE;
            REQ:  if (mem_req_ready) state_d = WAIT;
            WAIT: if (mem_resp_valid) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign lsu_ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            load_q        <= 1'b0;
            store_q       <= 1'b0;
            rd_wen_q      <= 1'b0;
            rd_q          <= '0;
            funct3_q      <= '0;
            addr_lo_q     <= '0;
            result_q      <= '0;
            mem_req_valid <= 1'b0;
            mem_wen       <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            lsu_valid     <= 1'b0;
            wen           <= 1'b0;
            waddr         <= '0;
            wdata         <= '0;
            lsu_fault     <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (exu_valid) begin
                        load_q    <= exu_load;
                        store_q   <= exu_store;
                        rd_wen_q  <= exu_rd_wen;
                        rd_q      <= exu_rd;
                        funct3_q  <= exu_funct3;
                        addr_lo_q <= exu_result[1:0];
                        result_q  <= exu_result;
                        if (acc_mem && !acc_fault) begin
                            mem_req_valid <= 1'b1;
                            mem_wen       <= acc_store;
                            mem_addr      <= {exu_result[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata     <= acc_store ? acc_wdata : '0;
                            mem_wstrb     <= acc_store ? acc_wstrb : 4'b0000;
                        end else begin
                            lsu_valid <= 1'b1;
                            wen       <= acc_wen;
                            waddr     <= exu_rd;
                            wdata     <= exu_result;
                            lsu_fault <= acc_fault;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) mem_req_valid <= 1'b0;
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        lsu_valid <= 1'b1;
                        wen       <= done_wen;
                        waddr     <= rd_q;
                        wdata     <= load_q ? load_fmt : result_q;
                        lsu_fault <= 1'b0;
                    end
                end
                default: begin
                    lsu_valid <= 1'b0;
                    wen       <= 1'b0;
                    lsu_fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store and writeback stage of the 32-bit RISC-V core. Accepts one instruction at a time from the execute stage and performs the aligned memory access for loads and stores over a valid/ready request + valid response port. It formats load data by size and sign and drives the one-cycle writeback strobe (`lsu_valid`, `wen`, `waddr`, `wdata`) that the register file commits on. Non-memory instructions pass through with one cycle of latency.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data width; fixed at 32 (strobe logic assumes 4 byte lanes)
- `REG_ADDR_WIDTH`, 5, register index width
---
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `exu_valid` in 1: execute stage offers an instruction
- `lsu_ready` out 1: stage can accept; equals (state == IDLE)
- `exu_result` in 32: ALU result; effective address for loads/stores, writeback value otherwise
- `exu_sdata` in 32: store data (rs2)
- `exu_rd` in 5: destination register
- `exu_rd_wen` in 1: instruction writes rd
- `exu_load` in 1: instruction is a load
- `exu_store` in 1: instruction is a store
- `exu_funct3` in 3: access size and sign
- `mem_req_valid` out 1: memory request valid
- `mem_req_ready` in 1: memory accepts request
- `mem_wen` out 1: request is a store
- `mem_addr` out 32: word-aligned address, {addr[31:2], 2'b00}
- `mem_wdata` out 32: store data replicated across lanes
- `mem_wstrb` out 4: byte enables; 0 for loads
- `mem_resp_valid` in 1: read data / store ack valid
- `mem_rdata` in 32: read data
- `lsu_valid` out 1: one-cycle writeback/completion strobe
- `wen` out 1: register write enable, qualified by `lsu_valid`
- `waddr` out 5: register write address
- `wdata` out 32: register write data
- `lsu_fault` out 1: with `lsu_valid`, the instruction was misaligned or had an illegal funct3

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, on `exu_valid`: latch all `exu_*` inputs.
  - Neither load nor store -> DONE.
  - Load or store, aligned and legal -> REQ.
  - Fault -> DONE with fault set.
- REQ: hold `mem_req_valid`=1 with stable `mem_*` fields. On `mem_req_ready` -> WAIT.
- WAIT: on `mem_resp_valid` -> DONE; capture `mem_rdata` for loads. A store only needs the response as an acknowledgement.
- DONE: `lsu_valid`=1 for exactly one cycle -> IDLE.
- Load funct3 decoding: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- Store funct3 decoding: 000 sb, 001 sh, 010 sw.
- Any other funct3 on a load or store is a fault.
- Misalignment: a halfword with addr[0]=1, or a word with addr[1:0]≠0, is a fault. No memory request is issued.
- Store strobes:
  - sb: `mem_wstrb` = 4'b0001 << addr[1:0], `mem_wdata` = {4{sdata[7:0]}}.
  - sh: `mem_wstrb` = 4'b0011 << addr[1:0], `mem_wdata` = {2{sdata[15:0]}}.
  - sw: `mem_wstrb` = 4'b1111, `mem_wdata` = sdata.
- Load data: shift `mem_rdata` right by 8*addr[1:0], then sign- or zero-extend bit 7 or bit 15 according to funct3.
- Writeback in DONE:
  - `waddr` = rd.
  - `wdata` = formatted load data for loads, latched `exu_result` otherwise.
  - `wen` = rd_wen & !store & !fault & (rd≠0).
- On a fault: `wen`=0 and `lsu_fault`=1.

## Timing
- Reset values:
  - State IDLE, so `lsu_ready`=1.
  - `mem_req_valid`=0, `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0.
  - `lsu_valid`=0, `wen`=0, `waddr`=0, `wdata`=0, `lsu_fault`=0.
- All outputs except `lsu_ready` are registered.
- Latency:
  - Non-memory instruction and faults: accepted at cycle N, `lsu_valid` at N+1.
  - Memory access with `mem_req_ready`=1 and the response one cycle after the handshake: accept at N, request at N+1, response at N+2, `lsu_valid` at N+3. Each stall cycle adds one.
- `mem_resp_valid` is sampled only in WAIT. The memory contract guarantees at least one cycle between request handshake and response.
- `mem_req_valid` must not drop, and `mem_*` fields must not change, until `mem_req_ready` is seen.
- `exu_valid` is ignored outside IDLE. The next instruction is accepted at the earliest in the cycle after DONE (`lsu_ready`=1 again).
- Asynchronous reset mid-operation (REQ/WAIT/DONE): return to IDLE immediately and clear all outputs. No writeback occurs for the aborted instruction.

## Test plan
- ALU op: rd=5, rd_wen=1, result=0x1234 -> one cycle later `lsu_valid`=1, `wen`=1, `waddr`=5, `wdata`=0x1234. `mem_req_valid` is never asserted.
- lb at 0x1003 with `mem_rdata`=0x80FF_0000, `mem_req_ready` low for 2 cycles -> `mem_addr`=0x1000. Request is held stable for 3 cycles. `wdata`=0xFFFF_FF80.
- lbu at 0x1003 with the same data -> `wdata`=0x0000_0080. lhu at 0x1002 -> `wdata`=0x0000_80FF.
- sh at 0x2002 with sdata=0xAAAA_BEEF -> `mem_wstrb`=4'b1100, `mem_wdata`=0xBEEF_BEEF, `mem_wen`=1. At completion `wen`=0.
- lw at 0x3001 -> no memory request. `lsu_valid`=1, `lsu_fault`=1, `wen`=0 at N+1.
- Load with rd=0 -> `wen`=0. Separately, `rst_n` pulled low in WAIT -> all outputs cleared, state returns to IDLE, and no `lsu_valid` for that instruction.
